// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding HI/LO (radix-2 Booth MULT, restoring DIV).
// Optional macro MULTDIV_ZERO_BYPASS_EN: a MULT with a zero operand completes without iterating.

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MultOrDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             ErroDiv
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               op_div;
    logic [WIDTH:0]     mcand;
    logic [2*WIDTH+1:0] booth, booth_next;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH-1:0]   rem, quo, dvs;
    logic [WIDTH-1:0]   rem_next, quo_next, rem_final, quo_final;
    logic [WIDTH:0]     shifted;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               div_zero, zero_byp, skip, last;

    assign div_zero = MultOrDiv && (B == '0);
`ifdef MULTDIV_ZERO_BYPASS_EN
    assign zero_byp = !MultOrDiv && ((A == '0) || (B == '0));
`else
    assign zero_byp = 1'b0;
`endif
    assign skip  = div_zero || zero_byp;
    assign last  = (count == LAST);
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Booth step: the accumulator carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow.
    always_comb begin
        acc_sum = booth[2*WIDTH+1:WIDTH+1];
        case (booth[1:0])
            2'b01:   acc_sum = booth[2*WIDTH+1:WIDTH+1] + mcand;
            2'b10:   acc_sum = booth[2*WIDTH+1:WIDTH+1] - mcand;
            default: ;
        endcase
        booth_next = {acc_sum[WIDTH], acc_sum, booth[WIDTH:1]};
    end

    // Restoring step on magnitudes; the sign fix-up is applied only to the final result.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {1'b0, dvs}) begin
            rem_next = WIDTH'(shifted - {1'b0, dvs});
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = WIDTH'(shifted);
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
        quo_final = neg_q ? -quo_next : quo_next;
        rem_final = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = skip ? DONE : RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are latched only on an accepted start; HI/LO change only on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            op_div  <= 1'b0;
            mcand   <= '0;
            booth   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            ErroDiv <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count   <= '0;
                        op_div  <= MultOrDiv;
                        mcand   <= {A[WIDTH-1], A};
                        booth   <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                        rem     <= '0;
                        quo     <= abs_a;
                        dvs     <= abs_b;
                        neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r   <= A[WIDTH-1];
                        ErroDiv <= div_zero;
                        if (zero_byp) begin
                            HI <= '0;
                            LO <= '0;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (op_div) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        if (last) begin
                            HI <= rem_final;
                            LO <= quo_final;
                        end
                    end else begin
                        booth <= booth_next;
                        if (last) begin
                            HI <= booth_next[2*WIDTH:WIDTH+1];
                            LO <= booth_next[WIDTH:1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
